// File: rtl/param_issue_queue.sv
// Unified issue queue with a collapsing, age-ordered store, multi-port CDB wakeup
// and oldest-first per-FU select. Entry 0 is always the oldest valid entry.
module param_issue_queue #(
   parameter int DEPTH   = 16,
   parameter int NUM_FU  = 3,
   parameter int NUM_CDB = 2,
   parameter int PTAG_W  = 7,
   parameter int XLEN    = 32,
   parameter int FU_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         flush_in,
   input  logic                         disp_valid_in,
   input  logic [FU_W-1:0]              disp_fu_in,
   input  logic [PTAG_W-1:0]            disp_rd_in,
   input  logic [PTAG_W-1:0]            disp_rs1_in,
   input  logic [PTAG_W-1:0]            disp_rs2_in,
   input  logic                         disp_rs1_rdy_in,
   input  logic                         disp_rs2_rdy_in,
   input  logic [XLEN-1:0]              disp_rs1_val_in,
   input  logic [XLEN-1:0]              disp_rs2_val_in,
   input  logic [XLEN-1:0]              disp_imm_in,
   input  logic [NUM_FU-1:0]            fu_ready_in,
   input  logic [NUM_CDB-1:0]           cdb_valid_in,
   input  logic [NUM_CDB*PTAG_W-1:0]    cdb_tag_in,
   input  logic [NUM_CDB*XLEN-1:0]      cdb_val_in,
   output logic [NUM_FU-1:0]            issue_valid_out,
   output logic [NUM_FU*PTAG_W-1:0]     issue_rd_out,
   output logic [NUM_FU*XLEN-1:0]       issue_rs1_val_out,
   output logic [NUM_FU*XLEN-1:0]       issue_rs2_val_out,
   output logic [NUM_FU*XLEN-1:0]       issue_imm_out,
   output logic                         full_out,
   output logic [$clog2(DEPTH+1)-1:0]   count_out
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(DEPTH);

   typedef struct packed {
      logic              valid;
      logic [FU_W-1:0]   fu;
      logic [PTAG_W-1:0] rd;
      logic [PTAG_W-1:0] tag1;
      logic [PTAG_W-1:0] tag2;
      logic              rdy1;
      logic              rdy2;
      logic [XLEN-1:0]   val1;
      logic [XLEN-1:0]   val2;
      logic [XLEN-1:0]   imm;
   } entry_t;

   entry_t             q     [DEPTH];
   entry_t             woke  [DEPTH];
   entry_t             nq    [DEPTH];
   entry_t             de;
   logic [IDX_W-1:0]   sel_idx [NUM_FU];
   logic [NUM_FU-1:0]  sel_hit;
   logic [DEPTH-1:0]   remove;
   logic               accept;
   logic [CNT_W-1:0]   dst;
   logic [CNT_W-1:0]   cnt_next;

   // Wakeup of stored entries and of the dispatched op; ascending k gives lowest port priority.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         woke[i] = q[i];
         for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid_in[k]) begin
               if (!woke[i].rdy1 && cdb_tag_in[k*PTAG_W +: PTAG_W] == q[i].tag1) begin
                  woke[i].rdy1 = 1'b1;
                  woke[i].val1 = cdb_val_in[k*XLEN +: XLEN];
               end
               if (!woke[i].rdy2 && cdb_tag_in[k*PTAG_W +: PTAG_W] == q[i].tag2) begin
                  woke[i].rdy2 = 1'b1;
                  woke[i].val2 = cdb_val_in[k*XLEN +: XLEN];
               end
            end
         end
      end

      de.valid = 1'b1;
      de.fu    = disp_fu_in;
      de.rd    = disp_rd_in;
      de.tag1  = disp_rs1_in;
      de.tag2  = disp_rs2_in;
      de.rdy1  = disp_rs1_rdy_in;
      de.rdy2  = disp_rs2_rdy_in;
      de.val1  = disp_rs1_val_in;
      de.val2  = disp_rs2_val_in;
      de.imm   = disp_imm_in;
      for (int unsigned k = 0; k < NUM_CDB; k++) begin
         if (cdb_valid_in[k]) begin
            if (!de.rdy1 && cdb_tag_in[k*PTAG_W +: PTAG_W] == disp_rs1_in) begin
               de.rdy1 = 1'b1;
               de.val1 = cdb_val_in[k*XLEN +: XLEN];
            end
            if (!de.rdy2 && cdb_tag_in[k*PTAG_W +: PTAG_W] == disp_rs2_in) begin
               de.rdy2 = 1'b1;
               de.val2 = cdb_val_in[k*XLEN +: XLEN];
            end
         end
      end
   end

   // Select uses registered readiness only, so a fresh wakeup waits one cycle.
   always_comb begin
      sel_hit = '0;
      remove  = '0;
      for (int unsigned f = 0; f < NUM_FU; f++) begin
         sel_idx[f] = '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!sel_hit[f] && q[i].valid && q[i].rdy1 && q[i].rdy2 &&
                q[i].fu == FU_W'(f) && fu_ready_in[f]) begin
               sel_hit[f] = 1'b1;
               sel_idx[f] = IDX_W'(i);
               remove[i]  = 1'b1;
            end
         end
      end
   end

   assign accept = disp_valid_in && !full_out && !flush_in && (int'(disp_fu_in) < NUM_FU);

   // Survivors are packed down in age order; the new op lands right behind them.
   always_comb begin
      dst = '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
         nq[j]       = q[j];
         nq[j].valid = 1'b0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (q[i].valid && !remove[i]) begin
            nq[dst[IDX_W-1:0]] = woke[i];
            dst                = dst + CNT_W'(1);
         end
      end
      if (accept && dst < CNT_W'(DEPTH)) begin
         nq[dst[IDX_W-1:0]] = de;
         dst                = dst + CNT_W'(1);
      end
      cnt_next = dst;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
         count_out         <= '0;
         full_out          <= 1'b0;
         issue_valid_out   <= '0;
         issue_rd_out      <= '0;
         issue_rs1_val_out <= '0;
         issue_rs2_val_out <= '0;
         issue_imm_out     <= '0;
      end else if (flush_in) begin
         for (int unsigned i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
         count_out       <= '0;
         full_out        <= 1'b0;
         issue_valid_out <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) q[i] <= nq[i];
         count_out <= cnt_next;
         full_out  <= (cnt_next == CNT_W'(DEPTH));
         for (int unsigned f = 0; f < NUM_FU; f++) begin
            issue_valid_out[f] <= sel_hit[f];
            if (sel_hit[f]) begin
               issue_rd_out[f*PTAG_W +: PTAG_W]    <= q[sel_idx[f]].rd;
               issue_rs1_val_out[f*XLEN +: XLEN]   <= q[sel_idx[f]].val1;
               issue_rs2_val_out[f*XLEN +: XLEN]   <= q[sel_idx[f]].val2;
               issue_imm_out[f*XLEN +: XLEN]       <= q[sel_idx[f]].imm;
            end
         end
      end
   end

endmodule

// File: tb/tb_param_issue_queue.sv
// Directed bench for param_issue_queue: expected issues are queued by the stimulus
// and matched (data and cycle) by an independent monitor on the issue ports.
module tb_param_issue_queue;

   localparam int DEPTH   = 16;
   localparam int NUM_FU  = 3;
   localparam int NUM_CDB = 2;
   localparam int PTAG_W  = 7;
   localparam int XLEN    = 32;

   logic                        clk;
   logic                        rstn;
   logic                        flush_in;
   logic                        disp_valid_in;
   logic [1:0]                  disp_fu_in;
   logic [PTAG_W-1:0]           disp_rd_in;
   logic [PTAG_W-1:0]           disp_rs1_in;
   logic [PTAG_W-1:0]           disp_rs2_in;
   logic                        disp_rs1_rdy_in;
   logic                        disp_rs2_rdy_in;
   logic [XLEN-1:0]             disp_rs1_val_in;
   logic [XLEN-1:0]             disp_rs2_val_in;
   logic [XLEN-1:0]             disp_imm_in;
   logic [NUM_FU-1:0]           fu_ready_in;
   logic [NUM_CDB-1:0]          cdb_valid_in;
   logic [NUM_CDB*PTAG_W-1:0]   cdb_tag_in;
   logic [NUM_CDB*XLEN-1:0]     cdb_val_in;
   logic [NUM_FU-1:0]           issue_valid_out;
   logic [NUM_FU*PTAG_W-1:0]    issue_rd_out;
   logic [NUM_FU*XLEN-1:0]      issue_rs1_val_out;
   logic [NUM_FU*XLEN-1:0]      issue_rs2_val_out;
   logic [NUM_FU*XLEN-1:0]      issue_imm_out;
   logic                        full_out;
   logic [4:0]                  count_out;

   param_issue_queue #(
      .DEPTH(DEPTH), .NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB), .PTAG_W(PTAG_W), .XLEN(XLEN)
   ) dut (
      .clk(clk), .rstn(rstn), .flush_in(flush_in),
      .disp_valid_in(disp_valid_in), .disp_fu_in(disp_fu_in), .disp_rd_in(disp_rd_in),
      .disp_rs1_in(disp_rs1_in), .disp_rs2_in(disp_rs2_in),
      .disp_rs1_rdy_in(disp_rs1_rdy_in), .disp_rs2_rdy_in(disp_rs2_rdy_in),
      .disp_rs1_val_in(disp_rs1_val_in), .disp_rs2_val_in(disp_rs2_val_in),
      .disp_imm_in(disp_imm_in), .fu_ready_in(fu_ready_in),
      .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_val_in(cdb_val_in),
      .issue_valid_out(issue_valid_out), .issue_rd_out(issue_rd_out),
      .issue_rs1_val_out(issue_rs1_val_out), .issue_rs2_val_out(issue_rs2_val_out),
      .issue_imm_out(issue_imm_out), .full_out(full_out), .count_out(count_out)
   );

   typedef struct {
      int          fu;
      int          rd;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] imm;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_issue(int fu, int rd, logic [31:0] v1, logic [31:0] v2,
                               logic [31:0] imm, int c);
      exp_t e;
      e.fu = fu; e.rd = rd; e.v1 = v1; e.v2 = v2; e.imm = imm; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cdb(logic [1:0] v, int t0, logic [31:0] d0, int t1, logic [31:0] d1);
      cdb_valid_in = v;
      cdb_tag_in   = {7'(t1), 7'(t0)};
      cdb_val_in   = {d1, d0};
   endtask

   task automatic disp(int fu, int rd, int t1, logic r1, logic [31:0] v1,
                       int t2, logic r2, logic [31:0] v2, logic [31:0] imm);
      disp_valid_in   = 1'b1;
      disp_fu_in      = 2'(fu);
      disp_rd_in      = 7'(rd);
      disp_rs1_in     = 7'(t1);
      disp_rs1_rdy_in = r1;
      disp_rs1_val_in = v1;
      disp_rs2_in     = 7'(t2);
      disp_rs2_rdy_in = r2;
      disp_rs2_val_in = v2;
      disp_imm_in     = imm;
      step();
      disp_valid_in   = 1'b0;
   endtask

   // Monitor: every issue strobe must match the oldest pending expectation for that port.
   always @(negedge clk) begin
      for (int p = 0; p < NUM_FU; p++) begin
         if (issue_valid_out[p]) begin
            int   idx;
            exp_t e;
            idx = -1;
            for (int j = 0; j < exp_q.size(); j++)
               if (idx < 0 && exp_q[j].fu == p) idx = j;
            if (idx < 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue port=%0d rd=0x%0h cycle=%0d", p,
                        issue_rd_out[p*PTAG_W +: PTAG_W], cyc);
            end else begin
               e = exp_q[idx];
               exp_q.delete(idx);
               chk("issue_rd",      issue_rd_out[p*PTAG_W +: PTAG_W], e.rd);
               chk("issue_rs1_val", issue_rs1_val_out[p*XLEN +: XLEN], e.v1);
               chk("issue_rs2_val", issue_rs2_val_out[p*XLEN +: XLEN], e.v2);
               chk("issue_imm",     issue_imm_out[p*XLEN +: XLEN], e.imm);
               chk("issue_cycle",   cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      rstn = 1'b0; flush_in = 1'b0; disp_valid_in = 1'b0; disp_fu_in = '0;
      disp_rd_in = '0; disp_rs1_in = '0; disp_rs2_in = '0;
      disp_rs1_rdy_in = 1'b0; disp_rs2_rdy_in = 1'b0;
      disp_rs1_val_in = '0; disp_rs2_val_in = '0; disp_imm_in = '0;
      fu_ready_in = '1;
      set_cdb(2'b00, 0, 0, 0, 0);
      step(); step();
      rstn = 1'b1;
      chk("reset_count", count_out, 0);
      chk("reset_full", full_out, 0);
      chk("reset_issue_valid", issue_valid_out, 0);
      chk("reset_issue_rd", issue_rd_out, 0);
      chk("reset_issue_data_zero",
          {63'd0, (issue_rs1_val_out == '0 && issue_rs2_val_out == '0 && issue_imm_out == '0)}, 1);

      // Wakeup of a stored entry via CDB port 0
      disp(0, 4, 1, 1'b1, 32'h1, 2, 1'b0, 32'h0, 32'h10);
      chk("t1_count_dispatch", count_out, 1);
      chk("t1_no_issue", issue_valid_out, 0);
      set_cdb(2'b01, 2, 32'h1, 0, 32'h0);
      step();
      set_cdb(2'b00, 0, 0, 0, 0);
      expect_issue(0, 4, 32'h1, 32'h1, 32'h10, cyc + 1);
      chk("t1_count_woken", count_out, 1);
      step();
      chk("t1_count_issued", count_out, 0);

      // Capture at dispatch from CDB port 1; port 0 carries an unrelated tag
      set_cdb(2'b11, 11, 32'h99, 9, 32'h55);
      disp(0, 8, 9, 1'b0, 32'hDEAD, 3, 1'b1, 32'h22, 32'h3);
      set_cdb(2'b00, 0, 0, 0, 0);
      chk("t2_count", count_out, 1);
      expect_issue(0, 8, 32'h55, 32'h22, 32'h3, cyc + 1);
      step();

      // Both CDB ports match: port 0 wins
      set_cdb(2'b11, 12, 32'h111, 12, 32'h222);
      disp(0, 13, 12, 1'b0, 32'h0, 14, 1'b1, 32'h5, 32'h4);
      set_cdb(2'b00, 0, 0, 0, 0);
      expect_issue(0, 13, 32'h111, 32'h5, 32'h4, cyc + 1);
      step();
      chk("t2_count_drained", count_out, 0);

      // Multi-FU issue gated by fu_ready_in
      fu_ready_in = '0;
      disp(0, 20, 1, 1'b1, 32'hA0, 1, 1'b1, 32'hA1, 32'hA2);
      disp(1, 21, 1, 1'b1, 32'hB0, 1, 1'b1, 32'hB1, 32'hB2);
      disp(2, 22, 1, 1'b1, 32'hC0, 1, 1'b1, 32'hC1, 32'hC2);
      chk("t3_count3", count_out, 3);
      fu_ready_in = 3'b101;
      expect_issue(0, 20, 32'hA0, 32'hA1, 32'hA2, cyc + 1);
      expect_issue(2, 22, 32'hC0, 32'hC1, 32'hC2, cyc + 1);
      step();
      chk("t3_count1", count_out, 1);
      step();
      chk("t3_count1_held", count_out, 1);
      fu_ready_in = '1;
      expect_issue(1, 21, 32'hB0, 32'hB1, 32'hB2, cyc + 1);
      step();
      chk("t3_count0", count_out, 0);

      // Age order across compaction, with a blocked older entry ahead
      fu_ready_in = '0;
      disp(1, 30, 1, 1'b1, 32'h30, 1, 1'b1, 32'h31, 32'h32);
      disp(0, 5, 1, 1'b1, 32'h50, 1, 1'b1, 32'h51, 32'h52);
      disp(0, 6, 1, 1'b1, 32'h60, 1, 1'b1, 32'h61, 32'h62);
      chk("t4_count3", count_out, 3);
      fu_ready_in = 3'b001;
      expect_issue(0, 5, 32'h50, 32'h51, 32'h52, cyc + 1);
      expect_issue(0, 6, 32'h60, 32'h61, 32'h62, cyc + 2);
      step();
      chk("t4_count2", count_out, 2);
      step();
      chk("t4_count1", count_out, 1);
      fu_ready_in = '1;
      expect_issue(1, 30, 32'h30, 32'h31, 32'h32, cyc + 1);
      step();
      chk("t4_count0", count_out, 0);

      // Fill to full; drop while full, even when an issue frees a slot
      for (int i = 0; i < DEPTH; i++)
         disp(0, i, 40, 1'b1, i, (i == 0) ? 50 : 60, 1'b0, 32'h0, 32'h100 + i);
      chk("t5_count_full", count_out, 16);
      chk("t5_full", full_out, 1);
      disp(0, 99, 1, 1'b1, 32'h9, 1, 1'b1, 32'h9, 32'h9);
      chk("t5_drop_count", count_out, 16);
      chk("t5_drop_full", full_out, 1);
      set_cdb(2'b01, 50, 32'h77, 0, 32'h0);
      step();
      set_cdb(2'b00, 0, 0, 0, 0);
      expect_issue(0, 0, 32'h0, 32'h77, 32'h100, cyc + 1);
      disp(0, 98, 1, 1'b1, 32'h8, 1, 1'b1, 32'h8, 32'h8);
      chk("t5_count_after_issue", count_out, 15);
      chk("t5_full_cleared", full_out, 0);
      flush_in = 1'b1;
      step();
      flush_in = 1'b0;
      chk("t5_flush_count", count_out, 0);

      // Flush beats concurrent dispatch and wakeup
      for (int i = 0; i < 5; i++)
         disp(1, 40 + i, 1, 1'b1, i, 60, 1'b0, 32'h0, i);
      chk("t6_count5", count_out, 5);
      flush_in = 1'b1;
      set_cdb(2'b01, 60, 32'h66, 0, 32'h0);
      disp(0, 77, 1, 1'b1, 32'h1, 1, 1'b1, 32'h1, 32'h1);
      flush_in = 1'b0;
      set_cdb(2'b00, 0, 0, 0, 0);
      chk("t6_flush_count", count_out, 0);
      chk("t6_flush_full", full_out, 0);
      chk("t6_flush_no_issue", issue_valid_out, 0);
      step();
      chk("t6_post_flush_no_issue", issue_valid_out, 0);
      disp(3, 91, 1, 1'b1, 32'h1, 1, 1'b1, 32'h1, 32'h1);
      chk("t6_bad_fu_dropped", count_out, 0);
      disp(2, 88, 1, 1'b1, 32'h8, 1, 1'b1, 32'h9, 32'hA);
      chk("t6_redispatch_count", count_out, 1);
      expect_issue(2, 88, 32'h8, 32'h9, 32'hA, cyc + 1);
      step();
      chk("t6_final_count", count_out, 0);

      step(); step(); step();
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
